// File: rtl/ifetch_port.sv
// Instruction-fetch port: runs one req/ack transaction per fetch_start and latches the word into ir.
// Optional per-fetch wait timeout is compiled in with `define IFETCH_TIMEOUT_EN.
module ifetch_port #(
  parameter logic [31:0] RESET_IR       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_start,
  input  logic [31:0] iad,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] ir,
  output logic        fetch_wait,
  output logic        fetch_done,
  output logic        misalign,
  output logic        timeout
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  localparam logic [31:0] ADDR_RST = 32'h0001_0000;

  state_t      r_state;
  logic        r_mem_req;
  logic [31:0] r_mem_addr;
  logic [31:0] r_ir;
  logic        r_fetch_done;
  logic        r_misalign;
  logic        r_timeout;
  logic        w_aligned;
  logic        w_expire;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("ifetch_port: TIMEOUT_CYCLES must be within 1..255");
  end

`ifdef IFETCH_TIMEOUT_EN
  localparam logic [7:0] TMO = 8'(TIMEOUT_CYCLES);
  logic [7:0] r_wait_cnt;
  // Count reaches TMO on this cycle if the ack is still missing.
  assign w_expire = (r_wait_cnt + 8'd1) == TMO;
`else
  assign w_expire = 1'b0;
`endif

  assign w_aligned  = (iad[1:0] == 2'b00);
  assign fetch_wait = (r_state != S_IDLE) | fetch_start;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_mem_req    <= 1'b0;
      r_mem_addr   <= ADDR_RST;
      r_ir         <= RESET_IR;
      r_fetch_done <= 1'b0;
      r_misalign   <= 1'b0;
      r_timeout    <= 1'b0;
`ifdef IFETCH_TIMEOUT_EN
      r_wait_cnt   <= 8'd0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (fetch_start) begin
            if (w_aligned) begin
              r_mem_addr <= iad;
              r_mem_req  <= 1'b1;
              r_state    <= S_REQ;
`ifdef IFETCH_TIMEOUT_EN
              r_wait_cnt <= 8'd0;
`endif
            end else begin
              // Misaligned: complete immediately without touching the bus.
              r_ir         <= RESET_IR;
              r_misalign   <= 1'b1;
              r_fetch_done <= 1'b1;
              r_state      <= S_DONE;
            end
          end
        end
        S_REQ: begin
          if (mem_ack) begin
            r_ir         <= mem_rdata;
            r_mem_req    <= 1'b0;
            r_fetch_done <= 1'b1;
            r_state      <= S_DONE;
          end else if (w_expire) begin
            r_ir         <= RESET_IR;
            r_mem_req    <= 1'b0;
            r_timeout    <= 1'b1;
            r_fetch_done <= 1'b1;
            r_state      <= S_DONE;
          end else begin
`ifdef IFETCH_TIMEOUT_EN
            r_wait_cnt <= r_wait_cnt + 8'd1;
`endif
          end
        end
        S_DONE: begin
          r_fetch_done <= 1'b0;
          r_misalign   <= 1'b0;
          r_timeout    <= 1'b0;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem_req    = r_mem_req;
  assign mem_addr   = r_mem_addr;
  assign ir         = r_ir;
  assign fetch_done = r_fetch_done;
  assign misalign   = r_misalign;
  assign timeout    = r_timeout;

endmodule

// File: tb/tb_ifetch_port.sv
// Bench for ifetch_port: directed scenarios plus random traffic against a transaction-level model.
module tb_ifetch_port;
  localparam logic [31:0] RIR = 32'h0000_0013;
  localparam int          TMO = 4;
`ifdef IFETCH_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fetch_start = 1'b0;
  logic [31:0] iad = '0;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] ir;
  logic        fetch_wait, fetch_done, misalign, timeout;

  ifetch_port #(.RESET_IR(RIR), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .fetch_start(fetch_start), .iad(iad),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ir(ir), .fetch_wait(fetch_wait), .fetch_done(fetch_done),
    .misalign(misalign), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model: an outstanding bus fetch (m_req) and a pending completion report (m_done).
  logic        m_req, m_done, m_mis, m_to;
  logic [31:0] m_addr, m_ir;
  int          m_waited;

  task automatic model_reset();
    m_req = 0; m_done = 0; m_mis = 0; m_to = 0;
    m_addr = 32'h0001_0000; m_ir = RIR; m_waited = 0;
  endtask

  task automatic model_step(logic s, logic [31:0] a, logic k, logic [31:0] d);
    if (m_done) begin
      m_done = 0; m_mis = 0; m_to = 0;
    end else if (m_req) begin
      if (k) begin
        m_ir = d; m_req = 0; m_done = 1;
      end else begin
        m_waited++;
        if (TO_EN && m_waited == TMO) begin
          m_ir = RIR; m_req = 0; m_to = 1; m_done = 1;
        end
      end
    end else if (s) begin
      if (a % 4 != 0) begin
        m_ir = RIR; m_mis = 1; m_done = 1;
      end else begin
        m_req = 1; m_addr = a; m_waited = 0;
      end
    end
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_regs();
    chk("mem_req", 32'(mem_req), 32'(m_req));
    chk("mem_addr", mem_addr, m_addr);
    chk("ir", ir, m_ir);
    chk("fetch_done", 32'(fetch_done), 32'(m_done));
    chk("misalign", 32'(misalign), 32'(m_mis));
    chk("timeout", 32'(timeout), 32'(m_to));
  endtask

  task automatic sample();
    @(negedge clk);
    check_regs();
  endtask

  task automatic drive(logic s, logic [31:0] a, logic k, logic [31:0] d);
    fetch_start = s; iad = a; mem_ack = k; mem_rdata = d;
    #1 chk("fetch_wait", 32'(fetch_wait), 32'(m_req | m_done | s));
    @(posedge clk);
    if (rst) model_step(s, a, k, d);
  endtask

  // Asynchronous reset in the middle of a cycle; leaves rst released at a negedge.
  task automatic reset_mid();
    #2 rst = 0;
    #1 model_reset();
    chk("rst_mem_req_async", 32'(mem_req), 32'd0);
    check_regs();
    @(posedge clk);
    sample();
    rst = 1;
  endtask

  initial begin
    model_reset();
    // Reset held across edges, even with a start request present.
    sample(); drive(1, 32'h0000_0040, 1, 32'hFFFF_FFFF);
    sample(); drive(1, 32'h0000_0040, 0, 32'h0);
    sample(); rst = 1;
    drive(0, 32'h0, 0, 32'h0);
    sample();
    chk("lit_rst_addr", mem_addr, 32'h0001_0000);
    chk("lit_rst_ir", ir, RIR);
    chk("lit_rst_req", 32'(mem_req), 32'd0);
    chk("lit_rst_wait", 32'(fetch_wait), 32'd0);

    // Single fetch with ack in the first REQ cycle.
    drive(1, 32'h0001_0000, 0, 32'h0);
    sample(); chk("lit_t2_req1", 32'(mem_req), 32'd1);
    drive(0, 32'h0001_0000, 1, 32'h8C22_0004);
    sample();
    chk("lit_t2_ir", ir, 32'h8C22_0004);
    chk("lit_t2_done", 32'(fetch_done), 32'd1);
    chk("lit_t2_req2", 32'(mem_req), 32'd0);
    drive(0, 32'h0, 0, 32'h0);
    sample(); chk("lit_t2_idle_wait", 32'(fetch_wait), 32'd0);

    // Delayed ack; iad and fetch_start wiggle during REQ.
    drive(1, 32'h0001_0004, 0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      sample(); chk("lit_t3_addr", mem_addr, 32'h0001_0004);
      drive(i == 2, 32'h1234_5678, 0, 32'h0);
    end
    sample(); drive(0, 32'h1234_5678, 1, 32'hA5A5_1234);
    sample();
    chk("lit_t3_ir", ir, 32'hA5A5_1234);
    chk("lit_t3_done", 32'(fetch_done), 32'd1);
    drive(0, 32'h0, 1, 32'h0BAD_0BAD);
    sample(); chk("lit_t3_one_done", 32'(fetch_done), 32'd0);
    chk("lit_t3_ir_hold", ir, 32'hA5A5_1234);
    drive(0, 32'h0, 0, 32'h0);

    // Misaligned address.
    sample(); drive(1, 32'h0001_0002, 0, 32'h0);
    sample();
    chk("lit_t4_mis", 32'(misalign), 32'd1);
    chk("lit_t4_done", 32'(fetch_done), 32'd1);
    chk("lit_t4_req", 32'(mem_req), 32'd0);
    chk("lit_t4_ir", ir, RIR);
    drive(0, 32'h0, 0, 32'h0);

    // Reset during a pending REQ, then a clean fetch.
    sample(); drive(1, 32'h0001_0008, 0, 32'h0);
    sample(); drive(0, 32'h0, 0, 32'h0);
    sample(); drive(0, 32'h0, 0, 32'h0);
    sample(); reset_mid();
    drive(1, 32'h0001_000C, 0, 32'h0);
    sample(); drive(0, 32'h0, 1, 32'h1111_2222);
    sample(); chk("lit_t5_ir", ir, 32'h1111_2222);
    drive(0, 32'h0, 0, 32'h0);

    // No ack for TMO cycles, then ack on exactly the TMO-th REQ cycle.
    sample(); drive(1, 32'h0001_0010, 0, 32'h0);
    for (int i = 0; i < TMO; i++) begin sample(); drive(0, 32'h0, 0, 32'h0); end
    sample();
`ifdef IFETCH_TIMEOUT_EN
    chk("lit_t6_to", 32'(timeout), 32'd1);
    chk("lit_t6_done", 32'(fetch_done), 32'd1);
    chk("lit_t6_ir", ir, RIR);
`else
    chk("lit_t6_still_req", 32'(mem_req), 32'd1);
`endif
    drive(0, 32'h0, 1, 32'h3333_4444);
    sample(); drive(0, 32'h0, 0, 32'h0);
    sample(); drive(0, 32'h0, 0, 32'h0);
    sample(); drive(1, 32'h0001_0014, 0, 32'h0);
    for (int i = 0; i < TMO - 1; i++) begin sample(); drive(0, 32'h0, 0, 32'h0); end
    sample(); drive(0, 32'h0, 1, 32'h5555_6666);
    sample();
    chk("lit_t7_ir", ir, 32'h5555_6666);
    chk("lit_t7_to", 32'(timeout), 32'd0);
    drive(0, 32'h0, 0, 32'h0);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] a;
      sample();
      if ($urandom_range(249) == 0) reset_mid();
      a = $urandom;
      if ($urandom_range(4) != 0) a[1:0] = 2'b00;
      drive($urandom_range(1), a, $urandom_range(2) == 0, $urandom);
    end
    sample();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ifetch_port.md
Name: ifetch_port

Overview:
- Memory-side fetch engine for the multicycle datapath. It consumes the instruction address (IAD) driven by the PC register and runs a req/ack transaction on the instruction-memory bus.
- It latches the returned word into the instruction register (ir).
- It drives fetch_wait, which the controller uses to hold pc_enable low until the fetch completes.

Parameters:
- RESET_IR, 32'h0000_0000: value loaded into ir at reset and on any aborted fetch.
- TIMEOUT_CYCLES, 255: number of REQ cycles without mem_ack before timeout. Used only with IFETCH_TIMEOUT_EN. Legal range 1..255.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- fetch_start  input  1  controller request to fetch at iad. Sampled only in IDLE.
- iad  input  32  instruction address from the PC register.
- mem_req  output  1  request to instruction memory (registered).
- mem_addr  output  32  word address to memory (registered, stable while mem_req=1).
- mem_ack  input  1  memory completion. mem_rdata is valid in the same cycle.
- mem_rdata  input  32  instruction word from memory.
- ir  output  32  instruction register (registered).
- fetch_wait  output  1  combinational. 1 when (state!=IDLE) or (state==IDLE and fetch_start).
- fetch_done  output  1  one-cycle pulse; ir is valid from this cycle on.
- misalign  output  1  one-cycle pulse, coincident with fetch_done, for a misaligned iad.
- timeout  output  1  one-cycle pulse, coincident with fetch_done, for a timed-out fetch (0 when the macro is off).

Behaviour:
- Reset values (rst=0, asynchronous): state=IDLE, mem_req=0, mem_addr=32'h0001_0000, ir=RESET_IR, fetch_done=0, misalign=0, timeout=0, wait counter=0.
- States: IDLE, REQ, DONE.
- IDLE, fetch_start=1, iad[1:0]==2'b00:
  - mem_addr<=iad, mem_req<=1, go to REQ.
- IDLE, fetch_start=1, iad[1:0]!=2'b00:
  - No memory request issued.
  - ir<=RESET_IR, misalign<=1, fetch_done<=1, go to DONE.
- IDLE, fetch_start=0: hold.
- REQ, mem_ack=1:
  - ir<=mem_rdata, mem_req<=0, fetch_done<=1, go to DONE.
- REQ, mem_ack=0: hold. mem_req and mem_addr stay unchanged.
- DONE: drop fetch_done, misalign and timeout to 0, go to IDLE.
- fetch_start outside IDLE is ignored. It is not queued.
- Latency, ack in the first REQ cycle:
  - start at cycle N.
  - mem_req=1 in cycle N+1.
  - ir updated and fetch_done=1 in cycle N+2.
  - fetch_wait=1 in cycles N..N+2.
  - IDLE in cycle N+3.
- General latency: fetch_done occurs 1 cycle after the ack cycle.
- Minimum back-to-back start spacing is 3 cycles.
- mem_ack while not in REQ is ignored, and ir is not modified.
- ir changes only on an accepted ack, a misalign, a timeout, or reset. It holds its value across idle periods so the decoder can read it over multiple cycles.
- iad changing during REQ has no effect, because the address is captured at start.
- Reset asserted mid-REQ: mem_req drops immediately (asynchronously) and no completion pulse is produced. After reset release the port is in IDLE.

Optional Feature:
- Macro: IFETCH_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entry to REQ and increments every REQ cycle with mem_ack=0.
  - When the counter reaches TIMEOUT_CYCLES with no ack: mem_req<=0, ir<=RESET_IR, timeout<=1, fetch_done<=1, go to DONE.
  - An ack in the same cycle the counter reaches TIMEOUT_CYCLES wins: the fetch completes normally and timeout=0.
- Undefined:
  - No counter is built, timeout is tied to 0, and REQ waits indefinitely for mem_ack.

Test Plan:
- Reset release, no start → mem_addr=0x00010000, ir=RESET_IR, mem_req=0, fetch_wait=0. Reset still asserted at a clock edge → outputs unchanged.
- iad=0x00010000, start at cycle 0, mem_ack=1 with mem_rdata=0x8C220004 in cycle 1 → mem_req=1 only in cycle 1, ir=0x8C220004 and fetch_done=1 in cycle 2, fetch_wait=1 in cycles 0..2.
- iad=0x00010004, ack delayed 5 cycles, iad changed to 0x12345678 and fetch_start pulsed during REQ → mem_addr stays 0x00010004 throughout, one fetch_done only, ir=ack data.
- iad=0x00010002, start → no mem_req, misalign=1 and fetch_done=1 one cycle later, ir=RESET_IR.
- Reset pulled low during cycle 3 of a pending REQ → mem_req=0 immediately, no fetch_done. A new fetch after release completes normally.
- With IFETCH_TIMEOUT_EN and TIMEOUT_CYCLES=4, no ack → timeout=1, fetch_done=1, ir=RESET_IR after 4 REQ cycles. Repeat with ack on the 4th REQ cycle → normal completion, timeout=0.
